// File: rtl/slc3_ctrl_pkg.sv
// Shared types and encodings for the SLC-3 control sequencer.
// The PAUSE states exist only when SLC3_PAUSE_EN is defined.
package slc3_ctrl_pkg;

    typedef enum logic [4:0] {
        S_HALTED,
        S_FETCH1,
        S_FETCH2,
        S_FETCH3,
        S_DECODE,
        S_ADD,
        S_AND,
        S_NOT,
        S_BR_TEST,
        S_BR_TAKE,
        S_JMP,
        S_JSR1,
        S_JSR2,
        S_LDR1,
        S_LDR2,
        S_LDR3,
        S_STR1,
        S_STR2,
        S_STR3
`ifdef SLC3_PAUSE_EN
        ,
        S_PAUSE1,
        S_PAUSE2
`endif
    } state_t;

    localparam logic [3:0] OP_BR    = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_JSR   = 4'b0100;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_LDR   = 4'b0110;
    localparam logic [3:0] OP_STR   = 4'b0111;
    localparam logic [3:0] OP_NOT   = 4'b1001;
    localparam logic [3:0] OP_JMP   = 4'b1100;
    localparam logic [3:0] OP_PAUSE = 4'b1101;

    localparam logic [1:0] PCMUX_INC  = 2'b00;
    localparam logic [1:0] PCMUX_BUS  = 2'b01;
    localparam logic [1:0] PCMUX_ADDR = 2'b10;

    localparam logic [1:0] ADDR2_ZERO  = 2'b00;
    localparam logic [1:0] ADDR2_OFF6  = 2'b01;
    localparam logic [1:0] ADDR2_OFF9  = 2'b10;
    localparam logic [1:0] ADDR2_OFF11 = 2'b11;

    localparam logic [1:0] ALUK_ADD   = 2'b00;
    localparam logic [1:0] ALUK_AND   = 2'b01;
    localparam logic [1:0] ALUK_NOT   = 2'b10;
    localparam logic [1:0] ALUK_PASSA = 2'b11;

    localparam int LD_MAR = 6;
    localparam int LD_MDR = 5;
    localparam int LD_IR  = 4;
    localparam int LD_CC  = 3;
    localparam int LD_REG = 2;
    localparam int LD_PC  = 1;
    localparam int LD_LED = 0;

    localparam int GATE_PC     = 3;
    localparam int GATE_MDR    = 2;
    localparam int GATE_ALU    = 1;
    localparam int GATE_MARMUX = 0;

    function automatic logic isWaitState(input state_t s);
        return (s == S_FETCH2) || (s == S_LDR2) || (s == S_STR3);
    endfunction

endpackage

// File: rtl/branch_enable.sv
// BEN flag: latched from IR[11:9] and the live NZP flags while the sequencer decodes.
module branch_enable
    import slc3_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_load,
    input  logic [2:0] i_irCc,
    input  logic [2:0] i_nzp,
    output logic       o_ben
);

    logic r_ben;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ben <= 1'b0;
        end else if (i_load) begin
            r_ben <= |(i_irCc & i_nzp);
        end
    end

    assign o_ben = r_ben;

endmodule

// File: rtl/slc3_control_fsm.sv
// SLC-3 Moore control FSM: fetch / decode / execute sequencing of the datapath.
// Define SLC3_PAUSE_EN to enable the PAUSE opcode (1101) with LED load and cont handshake.
module slc3_control_fsm
    import slc3_ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        cont,
    input  logic [15:0] ir,
    input  logic [2:0]  nzp,
    output logic [6:0]  ld,
    output logic [3:0]  gate,
    output logic [1:0]  pcmux,
    output logic        addr1mux,
    output logic [1:0]  addr2mux,
    output logic [1:0]  aluk,
    output logic        drmux,
    output logic        sr1mux,
    output logic        sr2mux,
    output logic        mem_oe,
    output logic        mem_we
);

    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT - 1);

    state_t     r_state;
    state_t     w_nextState;
    logic [3:0] r_waitCnt;
    logic       w_inWait;
    logic       w_waitDone;
    logic       w_ben;
    logic [7:0] w_unusedIr;

    assign w_inWait   = isWaitState(r_state);
    assign w_waitDone = (r_waitCnt == WAIT_LAST);
    assign w_unusedIr = {ir[8:6], ir[4:0]};

`ifndef SLC3_PAUSE_EN
    logic w_unusedCont;
    assign w_unusedCont = cont;
`endif

    branch_enable u_branchEnable (
        .clk    (clk),
        .reset  (reset),
        .i_load (r_state == S_DECODE),
        .i_irCc (ir[11:9]),
        .i_nzp  (nzp),
        .o_ben  (w_ben)
    );

    // The wait counter is zero in every non-wait state, so each wait state is entered at 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_HALTED;
            r_waitCnt <= 4'd0;
        end else begin
            r_state   <= w_nextState;
            r_waitCnt <= (w_inWait && !w_waitDone) ? r_waitCnt + 4'd1 : 4'd0;
        end
    end

    always_comb begin
        w_nextState = S_FETCH1;
        case (r_state)
            S_HALTED:  w_nextState = run ? S_FETCH1 : S_HALTED;
            S_FETCH1:  w_nextState = S_FETCH2;
            S_FETCH2:  w_nextState = w_waitDone ? S_FETCH3 : S_FETCH2;
            S_FETCH3:  w_nextState = S_DECODE;
            S_DECODE: begin
                case (ir[15:12])
                    OP_ADD:   w_nextState = S_ADD;
                    OP_AND:   w_nextState = S_AND;
                    OP_NOT:   w_nextState = S_NOT;
                    OP_BR:    w_nextState = S_BR_TEST;
                    OP_JMP:   w_nextState = S_JMP;
                    OP_JSR:   w_nextState = S_JSR1;
                    OP_LDR:   w_nextState = S_LDR1;
                    OP_STR:   w_nextState = S_STR1;
`ifdef SLC3_PAUSE_EN
                    OP_PAUSE: w_nextState = S_PAUSE1;
`endif
                    default:  w_nextState = S_FETCH1;
                endcase
            end
            S_BR_TEST: w_nextState = w_ben ? S_BR_TAKE : S_FETCH1;
            S_JSR1:    w_nextState = S_JSR2;
            S_LDR1:    w_nextState = S_LDR2;
            S_LDR2:    w_nextState = w_waitDone ? S_LDR3 : S_LDR2;
            S_STR1:    w_nextState = S_STR2;
            S_STR2:    w_nextState = S_STR3;
            S_STR3:    w_nextState = w_waitDone ? S_FETCH1 : S_STR3;
`ifdef SLC3_PAUSE_EN
            S_PAUSE1:  w_nextState = cont ? S_PAUSE2 : S_PAUSE1;
            S_PAUSE2:  w_nextState = cont ? S_PAUSE2 : S_FETCH1;
`endif
            default:   w_nextState = S_FETCH1;
        endcase
    end

    always_comb begin
        ld       = 7'd0;
        gate     = 4'd0;
        pcmux    = PCMUX_INC;
        addr1mux = 1'b0;
        addr2mux = ADDR2_ZERO;
        aluk     = ALUK_ADD;
        drmux    = 1'b0;
        sr1mux   = 1'b0;
        sr2mux   = 1'b0;
        mem_oe   = 1'b0;
        mem_we   = 1'b0;
        case (r_state)
            S_FETCH1: begin
                ld[LD_MAR]    = 1'b1;
                ld[LD_PC]     = 1'b1;
                gate[GATE_PC] = 1'b1;
            end
            S_FETCH2, S_LDR2: begin
                mem_oe     = 1'b1;
                ld[LD_MDR] = w_waitDone;
            end
            S_FETCH3: begin
                ld[LD_IR]      = 1'b1;
                gate[GATE_MDR] = 1'b1;
            end
            S_ADD, S_AND, S_NOT: begin
                ld[LD_REG]     = 1'b1;
                ld[LD_CC]      = 1'b1;
                gate[GATE_ALU] = 1'b1;
                sr1mux         = 1'b1;
                aluk           = (r_state == S_ADD) ? ALUK_ADD :
                                 (r_state == S_AND) ? ALUK_AND : ALUK_NOT;
                sr2mux         = (r_state != S_NOT) && ir[5];
            end
            S_BR_TAKE: begin
                ld[LD_PC] = 1'b1;
                pcmux     = PCMUX_ADDR;
                addr2mux  = ADDR2_OFF9;
            end
            S_JMP: begin
                ld[LD_PC] = 1'b1;
                pcmux     = PCMUX_ADDR;
                addr1mux  = 1'b1;
                sr1mux    = 1'b1;
            end
            S_JSR1: begin
                ld[LD_REG]    = 1'b1;
                drmux         = 1'b1;
                gate[GATE_PC] = 1'b1;
            end
            S_JSR2: begin
                ld[LD_PC] = 1'b1;
                pcmux     = PCMUX_ADDR;
                addr2mux  = ADDR2_OFF11;
            end
            S_LDR1, S_STR1: begin
                ld[LD_MAR]        = 1'b1;
                gate[GATE_MARMUX] = 1'b1;
                addr1mux          = 1'b1;
                addr2mux          = ADDR2_OFF6;
                sr1mux            = 1'b1;
            end
            S_LDR3: begin
                ld[LD_REG]     = 1'b1;
                ld[LD_CC]      = 1'b1;
                gate[GATE_MDR] = 1'b1;
            end
            S_STR2: begin
                ld[LD_MDR]     = 1'b1;
                gate[GATE_ALU] = 1'b1;
                aluk           = ALUK_PASSA;
            end
            S_STR3: mem_we = 1'b1;
`ifdef SLC3_PAUSE_EN
            S_PAUSE1: ld[LD_LED] = 1'b1;
`endif
            default: ;
        endcase
    end

endmodule
